// File: rtl/tdm_demux_pkg.sv
// Shared types and sizes for the 16-slot TDM demultiplexer.
package tdm_demux_pkg;
   localparam int SLOTS  = 16;
   localparam int SLOT_W = 4;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;
endpackage

// File: rtl/tdm_demux16_slot_decoder.sv
// One-hot write-enable for the assembly register, gated by the accept strobe.
module slot_decoder
   import tdm_demux_pkg::*;
(
   input  logic [SLOT_W-1:0] idx,
   input  logic              en,
   output logic [SLOTS-1:0]  we
);
   always_comb begin
      we = '0;
      if (en) we[idx] = 1'b1;
   end
endmodule

// File: rtl/tdm_demux16.sv
// Serial TDM to 16-bit frame demultiplexer with fsync framing and lock tracking.
//   state  | meaning
//   HUNT   | waiting for an fsync beat to start a frame
//   LOCKED | assembling slots; frame emitted after slot 15
module tdm_demux16
   import tdm_demux_pkg::*;
#(
   parameter bit FSYNC_CHECK = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   input  logic              din_valid,
   input  logic              fsync,
   output logic [SLOTS-1:0]  dout,
   output logic              dout_valid,
   output logic [SLOT_W-1:0] slot,
   output logic              locked,
   output logic              sync_err
);
   state_t              state;
   logic [SLOT_W-1:0]   slot_q;
   logic [SLOTS-1:0]    asm_q;
   logic [SLOTS-1:0]    asm_next;
   logic [SLOTS-1:0]    we;
   logic [SLOT_W-1:0]   wr_idx;
   logic                wr_en;
   logic                bad_start;
   logic                resync;
   logic                frame_done;

   slot_decoder u_dec (
      .idx (wr_idx),
      .en  (wr_en),
      .we  (we)
   );

   always_comb begin
      bad_start  = (state == LOCKED) && din_valid && (slot_q == '0) && !fsync && FSYNC_CHECK;
      resync     = (state == LOCKED) && din_valid && (slot_q != '0) && fsync;
      wr_en      = din_valid && ((state == LOCKED) ? !bad_start : fsync);
      wr_idx     = fsync ? '0 : slot_q;
      frame_done = wr_en && (state == LOCKED) && (wr_idx == SLOT_W'(SLOTS - 1));
      // A frame start clears stale bits left behind by a discarded partial frame.
      if (wr_en && fsync) asm_next = we & {SLOTS{din}};
      else                asm_next = (asm_q & ~we) | (we & {SLOTS{din}});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= HUNT;
         slot_q     <= '0;
         asm_q      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         dout_valid <= frame_done;
         sync_err   <= bad_start || resync;
         if (wr_en) begin
            asm_q  <= asm_next;
            slot_q <= wr_idx + SLOT_W'(1);
            state  <= LOCKED;
         end else if (bad_start) begin
            slot_q <= '0;
            state  <= HUNT;
         end
         if (frame_done) dout <= asm_next;
      end
   end

   assign slot   = slot_q;
   assign locked = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux16.sv
// Scoreboard bench for tdm_demux16, checking both fsync-check settings side by side.
module tb_tdm_demux16;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        din = 1'b0;
   logic        din_valid = 1'b0;
   logic        fsync = 1'b0;
   logic [15:0] dout, dout_nc;
   logic        dout_valid, dout_valid_nc;
   logic [3:0]  slot, slot_nc;
   logic        locked, locked_nc;
   logic        sync_err, sync_err_nc;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int err_cnt = 0;
   int nc_err_cnt = 0;
   int nc_dv_cnt = 0;
   logic [15:0] nc_last = '0;
   logic [15:0] exp_q[$];
   int          dv_cyc[$];

   tdm_demux16 #(.FSYNC_CHECK(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fsync(fsync),
      .dout(dout), .dout_valid(dout_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
   );

   tdm_demux16 #(.FSYNC_CHECK(1'b0)) dut_nc (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fsync(fsync),
      .dout(dout_nc), .dout_valid(dout_valid_nc), .slot(slot_nc), .locked(locked_nc),
      .sync_err(sync_err_nc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (dout_valid) begin
         dv_cyc.push_back(cyc);
         if (exp_q.size() == 0) chk("dv_unexpected", 32'd1, 32'd0);
         else                   chk("dout_sb", {16'h0, dout}, {16'h0, exp_q.pop_front()});
      end
      if (sync_err) err_cnt++;
      if (dout_valid_nc) begin
         nc_dv_cnt++;
         nc_last = dout_nc;
      end
      if (sync_err_nc) nc_err_cnt++;
   end

   task automatic beat(input logic d, input logic f);
      @(negedge clk);
      din = d; fsync = f; din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0; fsync = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [15:0] p, input bit gaps);
      logic [3:0] s;
      exp_q.push_back(p);
      for (int i = 0; i < 16; i++) begin
         if (gaps && ($urandom_range(1, 0) == 1)) begin
            s = slot;
            idle($urandom_range(3, 1));
            chk("slot_frozen", {28'h0, slot}, {28'h0, s});
         end
         beat(p[i], i == 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] p, q, r;
      int n;
      // reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout", {16'h0, dout}, 32'h0);
      chk("rst_dv", {31'h0, dout_valid}, 32'h0);
      chk("rst_serr", {31'h0, sync_err}, 32'h0);
      chk("rst_locked", {31'h0, locked}, 32'h0);
      chk("rst_slot", {28'h0, slot}, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      // HUNT ignores beats without fsync, then first frame
      beat(1'b1, 1'b0);
      beat(1'b1, 1'b0);
      chk("hunt_locked", {31'h0, locked}, 32'h0);
      chk("hunt_slot", {28'h0, slot}, 32'h0);
      send_frame(16'hA5C3, 1'b0);
      chk("f1_dv", {31'h0, dout_valid}, 32'h1);
      chk("f1_dout", {16'h0, dout}, 32'h0000A5C3);
      chk("f1_locked", {31'h0, locked}, 32'h1);
      chk("f1_slot", {28'h0, slot}, 32'h0);
      @(posedge clk); #1;
      chk("f1_dv_pulse", {31'h0, dout_valid}, 32'h0);

      // back-to-back frames
      send_frame(16'h1234, 1'b0);
      send_frame(16'hFFFF, 1'b0);
      @(negedge clk); #1;
      n = dv_cyc.size();
      chk("b2b_pulses", n, 3);
      if (n >= 2) chk("b2b_spacing", dv_cyc[n-1] - dv_cyc[n-2], 16);
      chk("b2b_no_serr", err_cnt, 0);

      // fsync at slot 7 -> resync
      p = 16'h0F0F;
      q = 16'h3C5A;
      for (int i = 0; i < 7; i++) beat(p[i], i == 0);
      chk("rs_slot7", {28'h0, slot}, 32'h7);
      exp_q.push_back(q);
      beat(q[0], 1'b1);
      chk("rs_serr", {31'h0, sync_err}, 32'h1);
      chk("rs_slot", {28'h0, slot}, 32'h1);
      chk("rs_dout_hold", {16'h0, dout}, 32'h0000FFFF);
      chk("rs_dv", {31'h0, dout_valid}, 32'h0);
      chk("rs_locked", {31'h0, locked}, 32'h1);
      @(posedge clk); #1;
      chk("rs_serr_pulse", {31'h0, sync_err}, 32'h0);
      for (int i = 1; i < 16; i++) beat(q[i], 1'b0);
      @(negedge clk); #1;
      chk("rs_nc_dout", {16'h0, nc_last}, {16'h0, q});

      // missing fsync at slot 0
      r = 16'h6E71;
      beat(r[0], 1'b0);
      chk("mf_serr", {31'h0, sync_err}, 32'h1);
      chk("mf_locked", {31'h0, locked}, 32'h0);
      chk("mf_slot", {28'h0, slot}, 32'h0);
      chk("mf_nc_serr", {31'h0, sync_err_nc}, 32'h0);
      chk("mf_nc_locked", {31'h0, locked_nc}, 32'h1);
      chk("mf_nc_slot", {28'h0, slot_nc}, 32'h1);
      for (int i = 1; i < 16; i++) beat(r[i], 1'b0);
      @(negedge clk); #1;
      chk("mf_ignored_slot", {28'h0, slot}, 32'h0);
      chk("mf_ignored_locked", {31'h0, locked}, 32'h0);
      chk("mf_dout_hold", {16'h0, dout}, {16'h0, q});
      chk("mf_nc_dout", {16'h0, nc_last}, {16'h0, r});

      // gaps inside a frame
      send_frame(16'h8001, 1'b1);
      @(negedge clk); #1;
      chk("gap_dout", {16'h0, dout}, 32'h00008001);
      chk("gap_nc_dout", {16'h0, nc_last}, 32'h00008001);

      // reset mid-frame at slot 9
      for (int i = 0; i < 9; i++) beat(1'b1, i == 0);
      chk("mr_slot9", {28'h0, slot}, 32'h9);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mr_dout", {16'h0, dout}, 32'h0);
      chk("mr_dv", {31'h0, dout_valid}, 32'h0);
      chk("mr_serr", {31'h0, sync_err}, 32'h0);
      chk("mr_locked", {31'h0, locked}, 32'h0);
      chk("mr_slot", {28'h0, slot}, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
      chk("mr_dout_still0", {16'h0, dout}, 32'h0);
      send_frame(16'h00F0, 1'b0);
      chk("mr_new_dout", {16'h0, dout}, 32'h000000F0);
      @(negedge clk); #1;

      // totals
      chk("sb_drained", exp_q.size(), 0);
      chk("dv_total", dv_cyc.size(), 6);
      chk("serr_total", err_cnt, 2);
      chk("nc_serr_total", nc_err_cnt, 1);
      chk("nc_dv_total", nc_dv_cnt, 7);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
